// File: rtl/operand_issue_latch.sv
// Decode-to-execute issue register: forwards each operand from RF or one of five result buses, then latches into EX.
// Latency: 1 cycle from decode inputs to the EX registers; DECODE_HOLD is combinational.
// Backpressure: a cache freeze holds every EX register, a hazard or flush loads a bubble. Optional counters via ISSUE_PERF_CNT_EN.
module operand_issue_latch #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [PC_W-1:0] PC_IN,
    input  logic [XLEN-1:0] IMM_IN,
    input  logic [4:0]      ALU_CTRL_IN,
    input  logic [4:0]      RD_IN,
    input  logic [1:0]      TYPE_IN,
    input  logic [XLEN-1:0] RF_RS1,
    input  logic [XLEN-1:0] RF_RS2,
    input  logic [XLEN-1:0] FWD_EX2,
    input  logic [XLEN-1:0] FWD_MEM1,
    input  logic [XLEN-1:0] FWD_MEM2,
    input  logic [XLEN-1:0] FWD_MEM3,
    input  logic [XLEN-1:0] FWD_WB,
    input  logic [2:0]      MUX1_SELECT,
    input  logic [2:0]      MUX2_SELECT,
    input  logic            STALL_ENABLE,
    input  logic            DATA_CACHE_READY,
    input  logic            INS_CACHE_READY,
    input  logic            FLUSH,
    output logic [XLEN-1:0] OP1_OUT,
    output logic [XLEN-1:0] OP2_OUT,
    output logic [XLEN-1:0] IMM_OUT,
    output logic [PC_W-1:0] PC_OUT,
    output logic [4:0]      ALU_CTRL_OUT,
    output logic [4:0]      RD_OUT,
    output logic [1:0]      TYPE_OUT,
    output logic            STALL_ENABLE_FB,
    output logic            DECODE_HOLD
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]     BUBBLE_CNT,
    output logic [31:0]     FREEZE_CNT
`endif
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_BUBBLE  = 2'd1;
    localparam logic [1:0] ST_FROZEN  = 2'd2;
    localparam logic [1:0] ST_FLUSHED = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            w_freeze;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_imm;
    logic [PC_W-1:0] r_pc;
    logic [4:0]      r_alu_ctrl;
    logic [4:0]      r_rd;
    logic [1:0]      r_type;

    assign w_freeze = !(DATA_CACHE_READY && INS_CACHE_READY);

    // Selects 6 and 7 are unused by the scoreboard and fall back to the register file.
    always_comb begin
        w_op1 = RF_RS1;
        case (MUX1_SELECT)
            3'd1:    w_op1 = FWD_EX2;
            3'd2:    w_op1 = FWD_MEM1;
            3'd3:    w_op1 = FWD_MEM2;
            3'd4:    w_op1 = FWD_MEM3;
            3'd5:    w_op1 = FWD_WB;
            default: w_op1 = RF_RS1;
        endcase
    end

    always_comb begin
        w_op2 = RF_RS2;
        case (MUX2_SELECT)
            3'd1:    w_op2 = FWD_EX2;
            3'd2:    w_op2 = FWD_MEM1;
            3'd3:    w_op2 = FWD_MEM2;
            3'd4:    w_op2 = FWD_MEM3;
            3'd5:    w_op2 = FWD_WB;
            default: w_op2 = RF_RS2;
        endcase
    end

    // Flush beats a cache freeze, which beats a hazard bubble.
    always_comb begin
        w_next_state = ST_RUN;
        if (FLUSH) begin
            w_next_state = ST_FLUSHED;
        end else if (w_freeze) begin
            w_next_state = ST_FROZEN;
        end else if (!STALL_ENABLE) begin
            w_next_state = ST_BUBBLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_RUN;
            r_op1      <= '0;
            r_op2      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_alu_ctrl <= '0;
            r_rd       <= '0;
            r_type     <= '0;
        end else begin
            r_state <= w_next_state;
            case (w_next_state)
                ST_FLUSHED, ST_BUBBLE: begin
                    r_rd   <= '0;
                    r_type <= '0;
                end
                ST_RUN: begin
                    r_op1      <= w_op1;
                    r_op2      <= w_op2;
                    r_imm      <= IMM_IN;
                    r_pc       <= PC_IN;
                    r_alu_ctrl <= ALU_CTRL_IN;
                    r_rd       <= RD_IN;
                    r_type     <= TYPE_IN;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_freeze_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bubble_cnt <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_next_state == ST_BUBBLE) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (w_next_state == ST_FROZEN) begin
                r_freeze_cnt <= r_freeze_cnt + 32'd1;
            end
        end
    end

    assign BUBBLE_CNT = r_bubble_cnt;
    assign FREEZE_CNT = r_freeze_cnt;
`endif

    assign OP1_OUT      = r_op1;
    assign OP2_OUT      = r_op2;
    assign IMM_OUT      = r_imm;
    assign PC_OUT       = r_pc;
    assign ALU_CTRL_OUT = r_alu_ctrl;
    assign RD_OUT       = r_rd;
    assign TYPE_OUT     = r_type;

    // A non-idle class in EX is valid only after an issue edge, possibly held across a freeze.
    assign STALL_ENABLE_FB = (r_type != 2'b00) && ((r_state == ST_RUN) || (r_state == ST_FROZEN));

    assign DECODE_HOLD = FLUSH ? 1'b0 : (!STALL_ENABLE || w_freeze);

endmodule

// File: tb/tb_operand_issue_latch.sv
// Bench for operand_issue_latch: vector table through a scoreboard queue, plus async-reset corner case.
module tb_operand_issue_latch;

    logic        CLK;
    logic        RST_N;
    logic [31:0] PC_IN, IMM_IN, RF_RS1, RF_RS2;
    logic [31:0] FWD_EX2, FWD_MEM1, FWD_MEM2, FWD_MEM3, FWD_WB;
    logic [4:0]  ALU_CTRL_IN, RD_IN;
    logic [1:0]  TYPE_IN;
    logic [2:0]  MUX1_SELECT, MUX2_SELECT;
    logic        STALL_ENABLE, DATA_CACHE_READY, INS_CACHE_READY, FLUSH;
    logic [31:0] OP1_OUT, OP2_OUT, IMM_OUT, PC_OUT;
    logic [4:0]  ALU_CTRL_OUT, RD_OUT;
    logic [1:0]  TYPE_OUT;
    logic        STALL_ENABLE_FB, DECODE_HOLD;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] BUBBLE_CNT, FREEZE_CNT;
`endif

    operand_issue_latch #(.XLEN(32), .PC_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .PC_IN(PC_IN), .IMM_IN(IMM_IN), .ALU_CTRL_IN(ALU_CTRL_IN),
        .RD_IN(RD_IN), .TYPE_IN(TYPE_IN),
        .RF_RS1(RF_RS1), .RF_RS2(RF_RS2),
        .FWD_EX2(FWD_EX2), .FWD_MEM1(FWD_MEM1), .FWD_MEM2(FWD_MEM2),
        .FWD_MEM3(FWD_MEM3), .FWD_WB(FWD_WB),
        .MUX1_SELECT(MUX1_SELECT), .MUX2_SELECT(MUX2_SELECT),
        .STALL_ENABLE(STALL_ENABLE), .DATA_CACHE_READY(DATA_CACHE_READY),
        .INS_CACHE_READY(INS_CACHE_READY), .FLUSH(FLUSH),
        .OP1_OUT(OP1_OUT), .OP2_OUT(OP2_OUT), .IMM_OUT(IMM_OUT), .PC_OUT(PC_OUT),
        .ALU_CTRL_OUT(ALU_CTRL_OUT), .RD_OUT(RD_OUT), .TYPE_OUT(TYPE_OUT),
        .STALL_ENABLE_FB(STALL_ENABLE_FB), .DECODE_HOLD(DECODE_HOLD)
`ifdef ISSUE_PERF_CNT_EN
        , .BUBBLE_CNT(BUBBLE_CNT), .FREEZE_CNT(FREEZE_CNT)
`endif
    );

    typedef struct {
        logic        fl, dc, ic, se;
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic [2:0]  s1, s2;
        logic [31:0] rs1, rs2;
        logic        e_hold, e_iss;
        logic [1:0]  e_ty;
        logic [4:0]  e_rd;
        logic        e_fb;
        logic [31:0] e_op1, e_op2;
    } vec_t;

    typedef struct {
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic        fb;
        logic [31:0] op1, op2, pc, imm;
        logic [4:0]  alu;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] m_pc = 0, m_imm = 0;
    logic [4:0]  m_alu = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic fl, dc, ic, se, input logic [1:0] ty, input logic [4:0] rd,
                       input logic [2:0] s1, s2, input logic [31:0] rs1, rs2,
                       input logic e_hold, e_iss, input logic [1:0] e_ty, input logic [4:0] e_rd,
                       input logic e_fb, input logic [31:0] e_op1, e_op2);
        vec_t v;
        v.fl = fl; v.dc = dc; v.ic = ic; v.se = se; v.ty = ty; v.rd = rd;
        v.s1 = s1; v.s2 = s2; v.rs1 = rs1; v.rs2 = rs2;
        v.e_hold = e_hold; v.e_iss = e_iss; v.e_ty = e_ty; v.e_rd = e_rd;
        v.e_fb = e_fb; v.e_op1 = e_op1; v.e_op2 = e_op2;
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e, g;
        logic [4:0] idx5;
        idx5 = idx[4:0];
        @(negedge CLK);
        FLUSH = v.fl; DATA_CACHE_READY = v.dc; INS_CACHE_READY = v.ic; STALL_ENABLE = v.se;
        TYPE_IN = v.ty; RD_IN = v.rd; MUX1_SELECT = v.s1; MUX2_SELECT = v.s2;
        RF_RS1 = v.rs1; RF_RS2 = v.rs2;
        PC_IN = 32'h1000 + 32'(idx * 4); IMM_IN = 32'h500 + 32'(idx); ALU_CTRL_IN = idx5;
        #1;
        chk($sformatf("v%0d decode_hold", idx), 64'(DECODE_HOLD), 64'(v.e_hold));
        if (v.e_iss) begin
            m_pc = PC_IN; m_imm = IMM_IN; m_alu = ALU_CTRL_IN;
        end
        e.ty = v.e_ty; e.rd = v.e_rd; e.fb = v.e_fb; e.op1 = v.e_op1; e.op2 = v.e_op2;
        e.pc = m_pc; e.imm = m_imm; e.alu = m_alu;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard_empty", idx), 64'd1, 64'd0);
        end else begin
            g = sb.pop_front();
            chk($sformatf("v%0d op1", idx), 64'(OP1_OUT), 64'(g.op1));
            chk($sformatf("v%0d op2", idx), 64'(OP2_OUT), 64'(g.op2));
            chk($sformatf("v%0d type", idx), 64'(TYPE_OUT), 64'(g.ty));
            chk($sformatf("v%0d rd", idx), 64'(RD_OUT), 64'(g.rd));
            chk($sformatf("v%0d fb", idx), 64'(STALL_ENABLE_FB), 64'(g.fb));
            chk($sformatf("v%0d pc", idx), 64'(PC_OUT), 64'(g.pc));
            chk($sformatf("v%0d imm", idx), 64'(IMM_OUT), 64'(g.imm));
            chk($sformatf("v%0d alu", idx), 64'(ALU_CTRL_OUT), 64'(g.alu));
        end
    endtask

    initial begin
        logic [31:0] exp_sel;
        FWD_EX2 = 32'hA1; FWD_MEM1 = 32'hA2; FWD_MEM2 = 32'hA3; FWD_MEM3 = 32'hA4; FWD_WB = 32'hA5;
        RST_N = 1'b0; FLUSH = 0; DATA_CACHE_READY = 1; INS_CACHE_READY = 1; STALL_ENABLE = 1;
        TYPE_IN = 0; RD_IN = 0; MUX1_SELECT = 0; MUX2_SELECT = 0; RF_RS1 = 0; RF_RS2 = 0;
        PC_IN = 0; IMM_IN = 0; ALU_CTRL_IN = 0;

        // Reset then issue
        add(0,1,1,1,2'b10,5,0,0,32'h11,32'h22, 0,1,2'b10,5,1,32'h11,32'h22);
        // Forwarding sweeps on both muxes
        for (int s = 0; s < 8; s++) begin
            exp_sel = (s >= 1 && s <= 5) ? 32'hA0 + 32'(s) : 32'hA0;
            add(0,1,1,1,2'b10,5'(s+1),3'(s),0,32'hA0,32'hB0, 0,1,2'b10,5'(s+1),1,exp_sel,32'hB0);
        end
        for (int s = 0; s < 8; s++) begin
            exp_sel = (s >= 1 && s <= 5) ? 32'hA0 + 32'(s) : 32'hA0;
            add(0,1,1,1,2'b01,5'(s+10),0,3'(s),32'hC0,32'hA0, 0,1,2'b01,5'(s+10),1,32'hC0,exp_sel);
        end
        // Hazard bubble x2, then dependent issue forwarding from MEM1
        add(0,1,1,1,2'b10,3,1,5,32'h10,32'h20, 0,1,2'b10,3,1,32'hA1,32'hA5);
        add(0,1,1,0,2'b10,4,0,0,32'h30,32'h31, 1,0,2'b00,0,0,32'hA1,32'hA5);
        add(0,1,1,0,2'b10,4,0,0,32'h30,32'h31, 1,0,2'b00,0,0,32'hA1,32'hA5);
        add(0,1,1,1,2'b01,4,2,0,32'h30,32'h40, 0,1,2'b01,4,1,32'hA2,32'h40);
        // Issue RD=7, then data-cache freeze for 3 edges with changing inputs
        add(0,1,1,1,2'b10,7,0,0,32'h77,32'h78, 0,1,2'b10,7,1,32'h77,32'h78);
        for (int k = 0; k < 3; k++)
            add(0,0,1,1,2'b11,9,3,3,32'h99+32'(k),32'h9A, 1,0,2'b10,7,1,32'h77,32'h78);
        // Flush during freeze wins, data held
        add(1,0,1,1,2'b10,8,1,1,32'h55,32'h56, 0,0,2'b00,0,0,32'h77,32'h78);
        // Idle-class issue leaves FB low
        add(0,1,1,1,2'b00,2,4,0,32'h12,32'h34, 0,1,2'b00,2,0,32'hA4,32'h34);
        // Instruction-cache freeze beats hazard
        add(0,1,0,0,2'b10,6,1,1,32'h01,32'h02, 1,0,2'b00,2,0,32'hA4,32'h34);
        add(0,1,1,1,2'b11,31,6,7,32'h61,32'h62, 0,1,2'b11,31,1,32'h61,32'h62);
        // Flush with hazard: bubble, not counted as a hazard, hold forced low
        add(1,1,1,0,2'b10,1,0,0,32'h00,32'h00, 0,0,2'b00,0,0,32'h61,32'h62);

        #2;
        chk("rst op1", 64'(OP1_OUT), 64'd0);
        chk("rst op2", 64'(OP2_OUT), 64'd0);
        chk("rst type", 64'(TYPE_OUT), 64'd0);
        chk("rst rd", 64'(RD_OUT), 64'd0);
        chk("rst fb", 64'(STALL_ENABLE_FB), 64'd0);
        chk("rst pc", 64'(PC_OUT), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

`ifdef ISSUE_PERF_CNT_EN
        chk("bubble_cnt", 64'(BUBBLE_CNT), 64'd2);
        chk("freeze_cnt", 64'(FREEZE_CNT), 64'd4);
`endif
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        // Async reset mid-freeze
        @(negedge CLK);
        FLUSH = 0; DATA_CACHE_READY = 1; INS_CACHE_READY = 1; STALL_ENABLE = 1;
        TYPE_IN = 2'b10; RD_IN = 7; MUX1_SELECT = 0; RF_RS1 = 32'h3C; PC_IN = 32'h2000;
        @(negedge CLK);
        DATA_CACHE_READY = 0; RF_RS1 = 32'h3D;
        @(posedge CLK);
        #1;
        chk("frozen rd", 64'(RD_OUT), 64'd7);
        chk("frozen op1", 64'(OP1_OUT), 64'h3C);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async rst op1", 64'(OP1_OUT), 64'd0);
        chk("async rst rd", 64'(RD_OUT), 64'd0);
        chk("async rst type", 64'(TYPE_OUT), 64'd0);
        chk("async rst fb", 64'(STALL_ENABLE_FB), 64'd0);
        chk("async rst pc", 64'(PC_OUT), 64'd0);
`ifdef ISSUE_PERF_CNT_EN
        chk("async rst freeze_cnt", 64'(FREEZE_CNT), 64'd0);
`endif
        @(negedge CLK);
        RST_N = 1'b1; DATA_CACHE_READY = 1; RD_IN = 12; RF_RS1 = 32'h5E;
        @(posedge CLK);
        #1;
        chk("post rst issue op1", 64'(OP1_OUT), 64'h5E);
        chk("post rst issue fb", 64'(STALL_ENABLE_FB), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
